// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full_adder cell is reused for WIDTH cycles, LSB first,
// behind a start/busy/done handshake. Results hold until the next completion.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_carry;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_part;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;
  logic               w_fa_sum;
  logic               w_fa_cout;
  logic               w_last;
  logic [WIDTH-1:0]   w_part_next;

  full_adder u_fa (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .cin  (r_carry),
    .sum  (w_fa_sum),
    .cout (w_fa_cout)
  );

  assign w_last      = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_part_next = {w_fa_sum, r_part[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // The result registers load only on the final RUN edge so they stay stable mid-operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_part  <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else if (r_state == IDLE) begin
      if (start) begin
        r_a     <= a;
        r_b     <= b;
        r_carry <= cin;
        r_cnt   <= '0;
      end
    end else if (r_state == RUN) begin
      r_part  <= w_part_next;
      r_carry <= w_fa_cout;
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_cnt   <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_sum  <= w_part_next;
        r_cout <= w_fa_cout;
      end
    end
  end

  assign busy = (r_state == RUN);
  assign done = (r_state == DONE);
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: an 8-bit instance driven from a vector
// table and a held-start run through a result scoreboard, plus a 2-bit exhaustive sweep.

module tb_serial_add_ctrl;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic [7:0] expSum;
      logic       expCout;
   } vec_t;

   typedef struct packed {
      logic       c;
      logic [7:0] s;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   logic       start8 = 1'b0;
   logic [7:0] a8 = '0;
   logic [7:0] b8 = '0;
   logic       cin8 = 1'b0;
   logic       busy8;
   logic       done8;
   logic [7:0] sum8;
   logic       cout8;

   logic       start2 = 1'b0;
   logic [1:0] a2 = '0;
   logic [1:0] b2 = '0;
   logic       cin2 = 1'b0;
   logic       busy2;
   logic       done2;
   logic [1:0] sum2;
   logic       cout2;

   int   errors = 0;
   int   checks = 0;
   exp_t scoreboard[$];
   vec_t vecs[6];

   // Two builds of the same design: the default 8-bit width and the minimum 2-bit width.
   serial_add_ctrl #(.WIDTH(8)) u_dut8 (
      .clk   (clk),
      .rst   (rst),
      .start (start8),
      .a     (a8),
      .b     (b8),
      .cin   (cin8),
      .busy  (busy8),
      .done  (done8),
      .sum   (sum8),
      .cout  (cout8)
   );

   serial_add_ctrl #(.WIDTH(2)) u_dut2 (
      .clk   (clk),
      .rst   (rst),
      .start (start2),
      .a     (a2),
      .b     (b2),
      .cin   (cin2),
      .busy  (busy2),
      .done  (done2),
      .sum   (sum2),
      .cout  (cout2)
   );

   // Free-running 10 ns clock.
   always #5 clk = ~clk;

   // Single comparison point: every check steps the counters used by the summary.
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Pops the scoreboard head and compares it with the 8-bit result outputs.
   task automatic popAndCompare(input string name);
      exp_t e;
      checkOutput({name, "_sb_has_entry"}, 32'(scoreboard.size() != 0), 32'd1);
      if (scoreboard.size() != 0) begin
         e = scoreboard.pop_front();
         checkOutput({name, "_sum"}, 32'(sum8), 32'(e.s));
         checkOutput({name, "_cout"}, 32'(cout8), 32'(e.c));
      end
   endtask

   // Runs one 8-bit addition: start pulse, latency and handshake checks, result compare.
   task automatic applyStimulus(input string name, input vec_t v);
      int   n;
      exp_t prev;
      @(negedge clk);
      a8     = v.a;
      b8     = v.b;
      cin8   = v.cin;
      start8 = 1'b1;
      scoreboard.push_back('{c: v.expCout, s: v.expSum});
      @(negedge clk);
      start8 = 1'b0;
      a8     = ~v.a;
      b8     = ~v.b;
      cin8   = ~v.cin;
      prev   = '{c: cout8, s: sum8};
      n      = 1;
      checkOutput({name, "_busy"}, 32'(busy8), 32'd1);
      while (!done8 && n < 20) begin
         @(negedge clk);
         n++;
         if (n == 8) checkOutput({name, "_hold_prev"}, 32'({cout8, sum8}), 32'(prev));
      end
      checkOutput({name, "_done_seen"}, 32'(done8), 32'd1);
      checkOutput({name, "_latency"}, 32'(n), 32'd9);
      checkOutput({name, "_busy_in_done"}, 32'(busy8), 32'd0);
      if (done8) popAndCompare(name);
      @(negedge clk);
      checkOutput({name, "_done_pulse_len"}, 32'(done8), 32'd0);
   endtask

   initial begin
      int   doneSeen;
      logic [2:0] exp2;
      int   n;

      vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
      vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
      vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
      vecs[3] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};
      vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
      vecs[5] = '{8'h01, 8'h02, 1'b0, 8'h03, 1'b0};

      repeat (2) @(negedge clk);
      rst = 1'b0;
      checkOutput("reset_busy", 32'(busy8), 32'd0);
      checkOutput("reset_done", 32'(done8), 32'd0);
      checkOutput("reset_result", 32'({cout8, sum8}), 32'd0);

      // Idle with start low: result stays cleared and done never fires.
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checkOutput("idle_result", 32'({cout8, sum8}), 32'd0);
         checkOutput("idle_done", 32'(done8), 32'd0);
      end

      for (int i = 0; i < 5; i++) applyStimulus($sformatf("vec%0d", i), vecs[i]);

      // Abort mid-RUN with an asynchronous reset pulse.
      @(negedge clk);
      a8     = 8'hAA;
      b8     = 8'h55;
      cin8   = 1'b0;
      start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("abort_pre_busy", 32'(busy8), 32'd1);
      #2 rst = 1'b1;
      #1;
      checkOutput("abort_busy", 32'(busy8), 32'd0);
      checkOutput("abort_done", 32'(done8), 32'd0);
      checkOutput("abort_result", 32'({cout8, sum8}), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      doneSeen = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done8) doneSeen++;
      end
      checkOutput("abort_no_done", 32'(doneSeen), 32'd0);
      applyStimulus("after_abort", vecs[5]);

      // Level-held start with operands changing every cycle.
      @(negedge clk);
      for (int c = 0; c < 30; c++) begin
         checkOutput("held_busy", 32'(busy8), 32'((c % 10) >= 1 && (c % 10) <= 8));
         checkOutput("held_done", 32'(done8), 32'((c % 10) == 9));
         if (done8) popAndCompare("held");
         a8     = 8'($urandom);
         b8     = 8'($urandom);
         cin8   = 1'($urandom);
         start8 = 1'b1;
         if ((c % 10) == 0)
            scoreboard.push_back(exp_t'({1'b0, a8} + {1'b0, b8} + 9'(cin8)));
         @(negedge clk);
      end
      start8 = 1'b0;
      checkOutput("held_sb_drained", 32'(scoreboard.size()), 32'd0);

      // Exhaustive sweep of the 2-bit build.
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         a2     = i[1:0];
         b2     = i[3:2];
         cin2   = i[4];
         start2 = 1'b1;
         exp2   = 3'(a2) + 3'(b2) + 3'(cin2);
         @(negedge clk);
         start2 = 1'b0;
         n = 1;
         while (!done2 && n < 10) begin
            @(negedge clk);
            n++;
         end
         checkOutput($sformatf("w2_latency_%0d", i), 32'(n), 32'd3);
         checkOutput($sformatf("w2_result_%0d", i), 32'({cout2, sum2}), 32'(exp2));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Bit-serial adder controller. It time-shares one full_adder instance (ports a, b, cin, sum, cout) across WIDTH cycles to add two WIDTH-bit operands plus a carry-in, LSB first. A start/busy/done handshake sequences each operation. Result registers hold the last completed sum until the next operation completes. This block is the sequencing layer that lets one 1-bit adder cell serve multi-bit additions in the Combinational_circuit/Adder area.

Parameters:
WIDTH, 8, operand and result width in bits. Legal range is 2..32.
CNT_W, $clog2(WIDTH+1), width of the internal bit counter. Derived; not overridden.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous reset, active-high.
start  input  1  request a new addition. Sampled only in IDLE.
a  input  WIDTH  operand A. Captured on the accepted start edge.
b  input  WIDTH  operand B. Captured on the accepted start edge.
cin  input  1  carry-in. Captured on the accepted start edge.
busy  output  1  high while state is RUN.
done  output  1  one-cycle pulse when sum/cout become valid.
sum  output  WIDTH  registered result a+b+cin, modulo 2^WIDTH.
cout  output  1  registered carry-out, bit WIDTH of a+b+cin.

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0, done=0, sum=0, cout=0. Operand shift registers, carry flop, counter and partial-result register are all cleared.
- The FSM has three states: IDLE, RUN, DONE. All outputs are registered or decoded from state; there is no combinational path from inputs to outputs.
- IDLE:
  - busy=0, done=0.
  - On an edge with start=1, load the A/B shift registers from a/b, load the carry flop from cin, clear the counter, and go to RUN.
  - With start=0, remain in IDLE.
- RUN (busy=1):
  - Each edge feeds the full_adder with the A shift-register LSB, the B shift-register LSB and the carry flop.
  - The full_adder sum bit shifts into the MSB of the partial-result register (right shift).
  - The full_adder cout is stored into the carry flop.
  - Both operand registers shift right by 1, and the counter increments.
  - On the edge where the counter reaches WIDTH-1 (the WIDTH-th RUN edge):
    - sum is loaded with the completed partial result, including the bit computed on that edge.
    - cout is loaded with that edge's full_adder cout.
    - state goes to DONE.
- DONE: done=1 and busy=0 for exactly one cycle, then unconditionally back to IDLE. start is ignored in DONE.
- Latency: if start is accepted at edge k, the FSM is in RUN during cycles k+1..k+WIDTH. sum/cout update at edge k+WIDTH, and done is high during the cycle following edge k+WIDTH. The next start can be accepted no earlier than edge k+WIDTH+2.
- sum/cout change only at the RUN-to-DONE edge or on reset. They are stable during RUN and hold indefinitely in IDLE.
- start asserted during RUN or DONE is ignored, not queued. A start still held high when IDLE is re-entered begins a new operation; a level-held start therefore runs back-to-back operations.
- a/b/cin may change freely after the accepted start edge without affecting the operation in flight.
- Overflow wraps modulo 2^WIDTH, and the carry-out appears on cout. Operands are unsigned; there is no signed-overflow flag.
- Reset mid-RUN or in DONE aborts immediately. done never pulses for the aborted operation, and sum/cout return to 0.
- After rst deasserts, the first eligible start edge is the first rising clk edge with rst=0.

Test Plan:
1. WIDTH=8; a=0x0F, b=0x01, cin=0, start pulsed at edge k.
   -> busy=1 for cycles k+1..k+8; done=1 only in cycle k+9; sum=0x10, cout=0.
2. a=0xFF, b=0x01, cin=0.
   -> sum=0x00, cout=1.
   Then a=0xFF, b=0xFF, cin=1.
   -> sum=0xFF, cout=1; the previous result holds until that done.
3. start held high continuously from IDLE for 30 cycles, with a/b toggled every cycle during RUN.
   -> Exactly one done every WIDTH+2 cycles, each result matching the operands present at its accepting edge; no start is accepted during RUN/DONE.
4. Start a=0xAA, b=0x55; assert rst at cycle k+4 for one cycle.
   -> busy, done, sum and cout all drop to 0 asynchronously; no done pulse follows.
   A subsequent start with a=0x01, b=0x02 -> sum=0x03, cout=0.
5. WIDTH=2 build; exhaustive sweep over all 32 combinations of a, b and cin.
   -> Each {cout,sum} equals a+b+cin; done occurs exactly 3 cycles after each accepted start edge.
6. Check after reset that sum=0 and cout=0 and that both hold through 10 idle cycles with start=0; done never asserts.
